load_aligner: RTL
=================

# load_aligner

Sequential load-data path for the rv32i core, between the LSU request stage and the data-memory port. It accepts one load request at a time and issues one or two word-aligned memory reads. A load that straddles a word boundary needs two reads. The block then shifts and merges the returned bytes and applies zero or sign extension per `reg_mask_e`. It replaces the purely combinational masking stage with handshaking on both sides, support for misaligned loads, and a configurable misaligned-access fault.

## Interface
- `XLEN`, 32: register and memory data width in bits; must be a power of two, at least 32. `BYTES = XLEN/8`, `OFS_W = $clog2(BYTES)`.
- `ADDR_W`, 32: byte-address width.
- `ALLOW_MISALIGNED`, 1: 1 splits word-crossing loads into two beats; 0 reports a fault instead.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: load request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in ADDR_W: byte address.
- `req_mask` in `reg_mask_e`: B/H/BX/HX/W.
- `req_rd` in 5: destination register tag, returned unchanged.
- `mem_req_valid` out 1: memory read request.
- `mem_req_ready` in 1: memory accepts the read.
- `mem_req_addr` out ADDR_W: word-aligned read address; low OFS_W bits are always 0.
- `mem_rsp_valid` in 1: read data valid. Exactly one per accepted read; never back-pressured.
- `mem_rsp_data` in XLEN: read data, little-endian.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out XLEN: aligned, extended load value.
- `rsp_rd` out 5: tag of the completed load.
- `rsp_fault` out 1: misaligned fault; `rsp_data` is 0 when set.

## Operation
- Size: B/BX = 1 byte, H/HX = 2 bytes, W (and any undefined encoding) = BYTES.
- `ofs = req_addr[OFS_W-1:0]`; `cross = ofs + size > BYTES`.
- Request capture: addr, mask, rd and ofs are registered when the request is accepted. Inputs are ignored afterwards.
- FSM states: IDLE, RD0, WT0, RD1, WT1, RESP.
- IDLE: `req_ready=1`. On accept go to RD0.
  - Exception: if `cross && !ALLOW_MISALIGNED`, go straight to RESP with `rsp_fault=1`, `rsp_data=0` and no memory access.
- RD0: `mem_req_valid=1`, `mem_req_addr` = aligned base. On `mem_req_ready` go to WT0.
- WT0: on `mem_rsp_valid`, store the low word. If `cross`, go to RD1; otherwise go to RESP.
- RD1: `mem_req_valid=1`, `mem_req_addr` = base + BYTES, wrapping modulo 2^ADDR_W. On `mem_req_ready` go to WT1.
- WT1: on `mem_rsp_valid`, store the high word and go to RESP.
- Assembly: `{hi, lo} >> (8*ofs)`, low XLEN bits kept; `hi=0` for a single beat.
- Masking:
  - B: zero-extend byte.
  - H: zero-extend half.
  - BX: sign-extend from bit 7.
  - HX: sign-extend from bit 15.
  - W / default: pass through.
- Masking is applied to the registered result, so `rsp_data` is a flop output.
- RESP: `rsp_valid=1`, with data, rd and fault stable until `rsp_ready`. On `rsp_ready` go to IDLE.
- Exactly one load is in flight at a time.
- `mem_rsp_valid` outside WT0/WT1 is a protocol error and is ignored.

## Timing
- Reset values: `req_ready=0` while `rst_n=0`, then 1 in IDLE. `mem_req_valid=0`, `mem_req_addr=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_rd=0`, `rsp_fault=0`. FSM=IDLE.
- Reset asserted mid-operation aborts immediately; any later `mem_rsp_valid` is dropped.
- Accept at cycle T, with memory always ready and responding one cycle after the request:
  - `mem_req_valid` at T+1.
  - Single beat: response at T+2, `rsp_valid` at T+3.
  - Two beats: second read at T+3, `rsp_valid` at T+5.
- Fault path: `rsp_valid` at T+1.
- `req_ready` is low from T+1 until the cycle after the `rsp_valid && rsp_ready` handshake.
- `mem_req_valid` and `mem_req_addr` are held stable until `mem_req_ready`. `mem_req_valid` is never withdrawn.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `reg_mask_e` stays in package `rv32i`.
- New in `rv32i`: `load_state_e` for the FSM, and function `mask_size(reg_mask_e)` returning the size in bytes.
- Extension logic is a natural sub-module, `load_extend`: combinational, parametrised by XLEN, inputs data and `reg_mask_e`. It is instantiated on the assembled word before the output register.

## Test plan
1. Aligned LW, addr 0x100, mem[0x100]=0x8899AABB -> `rsp_data`=0x8899AABB, one memory read, `rsp_valid` at T+3.
2. LB/LBU (BX/B), addr 0x103, mem[0x100]=0x8899AABB -> BX gives 0xFFFFFF88, B gives 0x00000088.
3. Misaligned LH (HX), addr 0x103, mem[0x100]=0x8899AABB, mem[0x104]=0x11223344 -> reads 0x100 then 0x104, `rsp_data`=0x00004488.
4. Misaligned LW, addr 0x102, same memory, `ALLOW_MISALIGNED=0` -> no `mem_req_valid`, `rsp_fault`=1, `rsp_data`=0, `rsp_valid` at T+1. Same load with `ALLOW_MISALIGNED=1` -> `rsp_data`=0x33448899.
5. Back-pressure: `mem_req_ready` low for 3 cycles and `rsp_ready` low for 4 cycles -> address and result held stable, `req_ready` stays 0, no duplicate read.
6. Reset and wrap:
   - `rst_n` pulsed low while in WT1 -> all outputs at reset values, stale `mem_rsp_valid` ignored, next LW correct.
   - Misaligned LW at 0xFFFFFFFE -> second read at 0x00000000.

Source files
------------

// File: rtl/load_aligner_pkg.sv
// Shared rv32i types for the load data path: load width encoding,
// aligner FSM states, and the byte-size helper for a load width.
package rv32i;

  typedef enum logic [2:0] {
    MASK_B  = 3'd0,
    MASK_H  = 3'd1,
    MASK_W  = 3'd2,
    MASK_BX = 3'd4,
    MASK_HX = 3'd5
  } reg_mask_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_WT0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_WT1  = 3'd4,
    ST_RESP = 3'd5
  } load_state_e;

  // Bytes touched by a load; full-word loads and unknown encodings use the
  // caller's word size.
  function automatic int unsigned mask_size(reg_mask_e m, int unsigned bytes = 4);
    case (m)
      MASK_B, MASK_BX: return 1;
      MASK_H, MASK_HX: return 2;
      default:         return bytes;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner_extend.sv
// Zero/sign extension of an aligned load word according to the load width.
module load_extend
  import rv32i::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  reg_mask_e       i_mask,
  output logic [XLEN-1:0] o_data
);

  // Select the extension for the requested width; full words pass through.
  always_comb begin
    o_data = i_data;
    case (i_mask)
      MASK_B:  o_data = {{(XLEN-8){1'b0}},       i_data[7:0]};
      MASK_H:  o_data = {{(XLEN-16){1'b0}},      i_data[15:0]};
      MASK_BX: o_data = {{(XLEN-8){i_data[7]}},  i_data[7:0]};
      MASK_HX: o_data = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_aligner.sv
// Sequential load aligner: issues one or two word reads per load, merges the
// returned words, extends the result and hands it out with a valid/ready pair.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new load request
// RD0     | first (or only) word read requested
// WT0     | waiting for first read data
// RD1     | second word read requested (load crosses a word boundary)
// WT1     | waiting for second read data
// RESP    | result (or fault) presented until the consumer takes it
module load_aligner
  import rv32i::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  reg_mask_e         req_mask,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int          OFS_W = $clog2(BYTES);

  load_state_e       r_state, w_next;
  logic [OFS_W-1:0]  r_ofs;
  reg_mask_e         r_mask;
  logic [4:0]        r_rd;
  logic              r_cross;
  logic [XLEN-1:0]   r_lo;
  logic              r_req_ready, r_mem_req_valid, r_rsp_valid, r_rsp_fault;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_rsp_data;

  logic [OFS_W-1:0]  w_ofs;
  logic              w_cross, w_fault, w_accept;
  logic [XLEN-1:0]   w_lo, w_hi, w_asm, w_ext;
  logic [OFS_W+2:0]  w_sh_amt;

  assign w_accept = req_valid && r_req_ready;
  assign w_ofs    = req_addr[OFS_W-1:0];
  assign w_cross  = (32'(w_ofs) + mask_size(req_mask, BYTES)) > BYTES;
  assign w_fault  = w_cross && !ALLOW_MISALIGNED;

  // Second beat supplies the high word; a single beat shifts in zeros.
  assign w_lo     = (r_state == ST_WT1) ? r_lo : mem_rsp_data;
  assign w_hi     = (r_state == ST_WT1) ? mem_rsp_data : '0;
  assign w_sh_amt = {r_ofs, 3'b000};
  assign w_asm    = XLEN'({w_hi, w_lo} >> w_sh_amt);

  load_extend #(.XLEN(XLEN)) u_extend (
    .i_data (w_asm),
    .i_mask (r_mask),
    .o_data (w_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_next = w_fault ? ST_RESP : ST_RD0;
      ST_RD0:  if (mem_req_ready) w_next = ST_WT0;
      ST_WT0:  if (mem_rsp_valid) w_next = r_cross ? ST_RD1 : ST_RESP;
      ST_RD1:  if (mem_req_ready) w_next = ST_WT1;
      ST_WT1:  if (mem_rsp_valid) w_next = ST_RESP;
      ST_RESP: if (rsp_ready)     w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Request capture, read address sequencing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofs           <= '0;
      r_mask          <= MASK_B;
      r_rd            <= '0;
      r_cross         <= 1'b0;
      r_lo            <= '0;
      r_req_ready     <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_fault     <= 1'b0;
      r_mem_addr      <= '0;
      r_rsp_data      <= '0;
    end else begin
      r_req_ready     <= (w_next == ST_IDLE);
      r_mem_req_valid <= (w_next == ST_RD0) || (w_next == ST_RD1);
      r_rsp_valid     <= (w_next == ST_RESP);
      if (w_accept) begin
        r_ofs       <= w_ofs;
        r_mask      <= req_mask;
        r_rd        <= req_rd;
        r_cross     <= w_cross;
        r_mem_addr  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        r_rsp_fault <= w_fault;
        if (w_fault) r_rsp_data <= '0;
      end
      if (r_state == ST_WT0 && mem_rsp_valid) begin
        r_lo <= mem_rsp_data;
        if (r_cross) r_mem_addr <= r_mem_addr + ADDR_W'(BYTES);
        else         r_rsp_data <= w_ext;
      end
      if (r_state == ST_WT1 && mem_rsp_valid) r_rsp_data <= w_ext;
    end
  end

  assign req_ready     = r_req_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_addr;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_rd        = r_rd;
  assign rsp_fault     = r_rsp_fault;

endmodule
